// File: rtl/stream_mux_pkg.sv
// Shared types and constants for the stream_mux packet multiplexer.
package stream_mux_pkg;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } state_e;

    localparam int MODE_SEL = 0;
    localparam int MODE_RR  = 1;

endpackage

// File: rtl/stream_mux_rr_pick.sv
// Combinational wrap-around priority search: first valid channel at or above ptr.
module rr_pick #(
    parameter int NCH = 8,
    parameter int SW  = $clog2(NCH)
) (
    input  logic [NCH-1:0] valid,
    input  logic [SW-1:0]  ptr,
    output logic [SW-1:0]  idx,
    output logic           any
);

    // Walk offsets from farthest to nearest so the nearest valid channel wins.
    always_comb begin
        logic [SW:0] sum;
        idx = '0;
        any = 1'b0;
        sum = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + (SW + 1)'(k);
            if (sum >= (SW + 1)'(NCH)) sum = sum - (SW + 1)'(NCH);
            if (valid[sum[SW-1:0]]) begin
                idx = sum[SW-1:0];
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_mux.sv
// Packet-aware N:1 stream multiplexer with a single registered output slot.
module stream_mux
    import stream_mux_pkg::*;
#(
    parameter int  NCH  = 8,
    parameter int  DW   = 8,
    parameter int  MODE = MODE_SEL,
    localparam int SW   = $clog2(NCH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH*DW-1:0] in_data,
    input  logic [NCH-1:0]    in_valid,
    input  logic [NCH-1:0]    in_last,
    output logic [NCH-1:0]    in_ready,
    input  logic [SW-1:0]     sel,
    output logic [DW-1:0]     out_data,
    output logic              out_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SW-1:0]     out_ch
);

    state_e        state_q, state_d;
    logic [SW-1:0] g, g_q, g_d;
    logic [SW-1:0] pick_idx;
    logic          pick_any;
    logic          cand, can_load, xfer_in, last_g;
    logic [DW-1:0] data_g;
    logic [DW-1:0] out_data_q;
    logic          out_last_q, out_valid_q;
    logic [SW-1:0] out_ch_q;

    generate
        if (MODE == MODE_RR) begin : gen_rr
            logic [SW-1:0] ptr_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    ptr_q <= '0;
                else if (xfer_in && last_g)
                    ptr_q <= (g == SW'(NCH - 1)) ? '0 : g + 1'b1;
            end

            rr_pick #(.NCH(NCH), .SW(SW)) u_pick (
                .valid (in_valid),
                .ptr   (ptr_q),
                .idx   (pick_idx),
                .any   (pick_any)
            );
        end else begin : gen_sel
            assign pick_idx = '0;
            assign pick_any = 1'b0;
        end
    endgenerate

    assign can_load = !out_valid_q | out_ready;

    // In LOCK the held channel is granted even while it idles mid-packet.
    always_comb begin
        g    = g_q;
        cand = 1'b1;
        if (state_q == ARB) begin
            if (MODE == MODE_RR) begin
                g    = pick_idx;
                cand = pick_any;
            end else begin
                g    = sel;
                cand = 1'b0;
                for (int i = 0; i < NCH; i++)
                    if (sel == SW'(i)) cand = in_valid[i];
            end
        end
    end

    // An out-of-range grant matches no channel, so nothing is selected.
    always_comb begin
        data_g   = '0;
        last_g   = 1'b0;
        in_ready = '0;
        for (int i = 0; i < NCH; i++) begin
            if (g == SW'(i)) begin
                data_g      = in_data[i*DW +: DW];
                last_g      = in_last[i];
                in_ready[i] = rst_n & can_load & cand;
            end
        end
    end

    assign xfer_in = |(in_valid & in_ready);

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        case (state_q)
            ARB: begin
                if (xfer_in && !last_g) begin
                    state_d = LOCK;
                    g_d     = g;
                end
            end
            LOCK: begin
                if (xfer_in && last_g) state_d = ARB;
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ARB;
            g_q         <= '0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            if (xfer_in) begin
                out_data_q  <= data_g;
                out_last_q  <= last_g;
                out_ch_q    <= g;
                out_valid_q <= 1'b1;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;

endmodule
